// File: rtl/cpu_cmd_port.sv
// CPU-clock master for the bridge command port: turns a valid/ready access into
// a level request / ack pulse handshake, with forced req-low recovery, timeout and sticky errors.
module cpu_cmd_port #(
   parameter int          RECOVER_CYCLES = 8,
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_mem_valid,
   input  logic        i_mem_sel,
   input  logic [31:0] i_mem_addr,
   input  logic [31:0] i_mem_wdata,
   input  logic [3:0]  i_mem_wstrb,
   output logic        o_mem_ready,
   output logic [31:0] o_mem_rdata,
   output logic        o_cpu_req,
   output logic [31:0] o_cpu_addr,
   output logic [31:0] o_cpu_wdata,
   output logic [3:0]  o_cpu_wstrb,
   input  logic        i_cpu_ack_pulse,
   input  logic [31:0] i_cpu_rdata,
   output logic        o_err_timeout,
   output logic        o_err_partial,
   input  logic        i_err_clr
);

   // state   | meaning
   // IDLE    | waiting for a CPU access to the command window
   // REQ     | o_cpu_req high, waiting for ack or timeout
   // RECOVER | o_cpu_req held low so the far side sees a fresh edge next time
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REQ     = 2'd1;
   localparam logic [1:0] ST_RECOVER = 2'd2;

   localparam int RW = $clog2(RECOVER_CYCLES) + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

   logic [1:0]    state;
   logic [RW-1:0] rec_cnt;
   logic [TW-1:0] to_cnt;
   logic          accept;
   logic          wstrb_ok;
   logic          to_hit;
   logic          set_partial;
   logic          set_timeout;

   assign accept      = (state == ST_IDLE) & i_mem_valid & i_mem_sel;
   assign wstrb_ok    = (i_mem_wstrb == 4'b1111) | (i_mem_wstrb == 4'b0000);
   assign to_hit      = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign set_partial = accept & ~wstrb_ok;
   // an ack in the timeout cycle wins, so the timeout only fires without one
   assign set_timeout = (state == ST_REQ) & ~i_cpu_ack_pulse & to_hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         o_cpu_req   <= 1'b0;
         o_mem_ready <= 1'b0;
         o_mem_rdata <= '0;
         o_cpu_addr  <= '0;
         o_cpu_wdata <= '0;
         o_cpu_wstrb <= '0;
         rec_cnt     <= '0;
         to_cnt      <= '0;
      end else begin
         o_mem_ready <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (wstrb_ok) begin
                     o_cpu_addr  <= i_mem_addr;
                     o_cpu_wdata <= i_mem_wdata;
                     o_cpu_wstrb <= i_mem_wstrb;
                     o_cpu_req   <= 1'b1;
                     to_cnt      <= '0;
                     state       <= ST_REQ;
                  end else begin
                     // partial writes are refused locally and never forwarded
                     o_mem_ready <= 1'b1;
                     rec_cnt     <= '0;
                     state       <= ST_RECOVER;
                  end
               end
            end
            ST_REQ: begin
               if (i_cpu_ack_pulse) begin
                  o_cpu_req   <= 1'b0;
                  o_mem_ready <= 1'b1;
                  if (o_cpu_wstrb == 4'b0000) begin
                     o_mem_rdata <= i_cpu_rdata;
                  end
                  rec_cnt <= RW'(RECOVER_CYCLES);
                  state   <= ST_RECOVER;
               end else if (to_hit) begin
                  o_cpu_req   <= 1'b0;
                  o_mem_ready <= 1'b1;
                  o_mem_rdata <= TIMEOUT_RDATA;
                  rec_cnt     <= RW'(RECOVER_CYCLES);
                  state       <= ST_RECOVER;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            ST_RECOVER: begin
               o_cpu_req <= 1'b0;
               if (rec_cnt <= RW'(1)) begin
                  rec_cnt <= '0;
                  state   <= ST_IDLE;
               end else begin
                  rec_cnt <= rec_cnt - RW'(1);
               end
            end
            default: begin
               o_cpu_req <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_err_timeout <= 1'b0;
         o_err_partial <= 1'b0;
      end else begin
         if (set_timeout) begin
            o_err_timeout <= 1'b1;
         end else if (i_err_clr) begin
            o_err_timeout <= 1'b0;
         end
         if (set_partial) begin
            o_err_partial <= 1'b1;
         end else if (i_err_clr) begin
            o_err_partial <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cpu_cmd_port.sv
// Directed bench for cpu_cmd_port: a CPU driver plus a command-handler model
// that acks a programmable number of cycles after req rises.
module tb_cpu_cmd_port;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        i_mem_valid = 1'b0;
   logic        i_mem_sel = 1'b0;
   logic [31:0] i_mem_addr = '0;
   logic [31:0] i_mem_wdata = '0;
   logic [3:0]  i_mem_wstrb = '0;
   logic        o_mem_ready;
   logic [31:0] o_mem_rdata;
   logic        o_cpu_req;
   logic [31:0] o_cpu_addr;
   logic [31:0] o_cpu_wdata;
   logic [3:0]  o_cpu_wstrb;
   logic        i_cpu_ack_pulse;
   logic [31:0] i_cpu_rdata;
   logic        o_err_timeout;
   logic        o_err_partial;
   logic        i_err_clr = 1'b0;

   logic        model_ack = 1'b0;
   logic [31:0] model_rdata = '0;
   logic        force_ack = 1'b0;
   logic [31:0] stray_rdata = '0;
   logic        ack_en = 1'b0;
   int          ack_delay = 1;
   logic [31:0] ack_data = '0;

   int          rises = 0;
   int          high_cnt = 0;
   int          low_cnt = 0;
   int          last_low = 0;
   int          last_high = 0;
   logic        prev_req = 1'b0;
   logic        unstable = 1'b0;
   logic [31:0] hold_addr = '0;
   logic [31:0] hold_wdata = '0;

   int          n_tests = 0;
   int          n_fail = 0;

   assign i_cpu_ack_pulse = model_ack | force_ack;
   assign i_cpu_rdata     = force_ack ? stray_rdata : model_rdata;

   cpu_cmd_port dut (
      .clk             (clk),
      .reset           (reset),
      .i_mem_valid     (i_mem_valid),
      .i_mem_sel       (i_mem_sel),
      .i_mem_addr      (i_mem_addr),
      .i_mem_wdata     (i_mem_wdata),
      .i_mem_wstrb     (i_mem_wstrb),
      .o_mem_ready     (o_mem_ready),
      .o_mem_rdata     (o_mem_rdata),
      .o_cpu_req       (o_cpu_req),
      .o_cpu_addr      (o_cpu_addr),
      .o_cpu_wdata     (o_cpu_wdata),
      .o_cpu_wstrb     (o_cpu_wstrb),
      .i_cpu_ack_pulse (i_cpu_ack_pulse),
      .i_cpu_rdata     (i_cpu_rdata),
      .o_err_timeout   (o_err_timeout),
      .o_err_partial   (o_err_partial),
      .i_err_clr       (i_err_clr)
   );

   always #5 clk = ~clk;

   // command-handler model and req edge monitor, sampled on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         model_ack = 1'b0;
         if (o_cpu_req) begin
            if (!prev_req) begin
               rises++;
               last_low   = low_cnt;
               high_cnt   = 0;
               hold_addr  = o_cpu_addr;
               hold_wdata = o_cpu_wdata;
            end else if (o_cpu_addr != hold_addr || o_cpu_wdata != hold_wdata) begin
               unstable = 1'b1;
            end
            high_cnt++;
            low_cnt = 0;
            if (ack_en && high_cnt == ack_delay) begin
               model_ack   = 1'b1;
               model_rdata = ack_data;
            end
         end else begin
            if (prev_req) last_high = high_cnt;
            low_cnt++;
         end
         prev_req = o_cpu_req;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
      i_mem_valid = 1'b1;
      i_mem_sel   = 1'b1;
      i_mem_addr  = addr;
      i_mem_wdata = wdata;
      i_mem_wstrb = wstrb;
   endtask

   task automatic release_cpu();
      i_mem_valid = 1'b0;
      i_mem_sel   = 1'b0;
   endtask

   task automatic idle_gap();
      release_cpu();
      repeat (12) @(negedge clk);
      #1;
   endtask

   // counts falling edges until ready; cyc==1 is the first falling edge after acceptance
   task automatic wait_ready(input int budget, output int cyc, output logic [31:0] rd,
                             output logic req1);
      cyc  = 0;
      rd   = '0;
      req1 = 1'b0;
      while (1) begin
         @(negedge clk);
         #1;
         cyc++;
         if (cyc == 1) req1 = o_cpu_req;
         if (o_mem_ready) begin
            rd = o_mem_rdata;
            break;
         end
         if (cyc >= budget) begin
            chk("ready_seen", 32'(o_mem_ready), 32'd1);
            break;
         end
      end
   endtask

   initial begin
      int          cyc;
      logic [31:0] rd;
      logic        req1;
      int          r0;

      repeat (2) @(negedge clk);
      #1;
      chk("rst_req",   32'(o_cpu_req), 32'd0);
      chk("rst_ready", 32'(o_mem_ready), 32'd0);
      chk("rst_rdata", o_mem_rdata, 32'd0);
      chk("rst_addr",  o_cpu_addr, 32'd0);
      chk("rst_wstrb", 32'(o_cpu_wstrb), 32'd0);
      chk("rst_errs",  32'({o_err_timeout, o_err_partial}), 32'd0);
      reset = 1'b0;
      idle_gap();

      // read 0x80, ack 5 cycles after req rises
      ack_en = 1'b1; ack_delay = 5; ack_data = 32'h0000_0004;
      drive(32'h80, 32'h0, 4'h0);
      wait_ready(50, cyc, rd, req1);
      release_cpu();
      chk("rd_req_latency", 32'(req1), 32'd1);
      chk("rd_cycles", 32'(cyc), 32'd6);
      chk("rd_data", rd, 32'h0000_0004);
      chk("rd_addr", o_cpu_addr, 32'h80);
      @(negedge clk); #1;
      chk("rd_ready_pulse", 32'(o_mem_ready), 32'd0);
      chk("rd_req_dropped", 32'(o_cpu_req), 32'd0);
      idle_gap();

      // full write: fields held for the whole REQ, rdata keeps the read value
      ack_delay = 3; unstable = 1'b0;
      drive(32'h00, 32'h636D_0140, 4'hF);
      @(negedge clk); #1;
      chk("wr_addr",  o_cpu_addr, 32'h0);
      chk("wr_wdata", o_cpu_wdata, 32'h636D_0140);
      chk("wr_wstrb", 32'(o_cpu_wstrb), 32'hF);
      wait_ready(50, cyc, rd, req1);
      release_cpu();
      chk("wr_cycles", 32'(cyc), 32'd3);
      chk("wr_rdata_held", rd, 32'h0000_0004);
      chk("wr_stable", 32'(unstable), 32'd0);
      idle_gap();

      // back-to-back reads with valid held: two rises, 9 low cycles between them
      r0 = rises; ack_delay = 3; ack_data = 32'h0000_0011;
      drive(32'h84, 32'h0, 4'h0);
      wait_ready(50, cyc, rd, req1);
      ack_data = 32'h0000_0022;
      chk("b2b_first_cycles", 32'(cyc), 32'd4);
      chk("b2b_first_data", rd, 32'h0000_0011);
      wait_ready(50, cyc, rd, req1);
      release_cpu();
      chk("b2b_second_cycles", 32'(cyc), 32'd12);
      chk("b2b_second_data", rd, 32'h0000_0022);
      chk("b2b_req_low", 32'(last_low), 32'd9);
      chk("b2b_rises", 32'(rises - r0), 32'd2);
      idle_gap();

      // partial write with clear held on the same edge: set wins, no request
      r0 = rises; i_err_clr = 1'b1;
      drive(32'h08, 32'h1111_2222, 4'b0011);
      wait_ready(20, cyc, rd, req1);
      release_cpu();
      i_err_clr = 1'b0;
      chk("part_cycles", 32'(cyc), 32'd1);
      chk("part_req", 32'(req1), 32'd0);
      chk("part_err", 32'(o_err_partial), 32'd1);
      chk("part_no_timeout", 32'(o_err_timeout), 32'd0);
      repeat (12) @(negedge clk);
      #1;
      chk("part_no_rise", 32'(rises - r0), 32'd0);
      i_err_clr = 1'b1;
      @(negedge clk); #1;
      i_err_clr = 1'b0;
      chk("part_cleared", 32'(o_err_partial), 32'd0);
      idle_gap();

      // no ack: timeout after 1024 req-high cycles
      ack_en = 1'b0;
      drive(32'h80, 32'h0, 4'h0);
      wait_ready(2000, cyc, rd, req1);
      release_cpu();
      chk("to_cycles", 32'(cyc), 32'd1025);
      chk("to_rdata", rd, 32'hDEAD_BEEF);
      chk("to_err", 32'(o_err_timeout), 32'd1);
      chk("to_req_high", 32'(last_high), 32'd1024);
      i_err_clr = 1'b1;
      @(negedge clk); #1;
      i_err_clr = 1'b0;
      chk("to_cleared", 32'(o_err_timeout), 32'd0);
      idle_gap();

      // ack lands in the same cycle the timeout would fire: ack wins
      ack_en = 1'b1; ack_delay = 1024; ack_data = 32'h5A5A_0001;
      drive(32'h80, 32'h0, 4'h0);
      wait_ready(2000, cyc, rd, req1);
      release_cpu();
      chk("late_ack_cycles", 32'(cyc), 32'd1025);
      chk("late_ack_data", rd, 32'h5A5A_0001);
      chk("late_ack_no_err", 32'(o_err_timeout), 32'd0);
      idle_gap();

      // stray ack in IDLE is ignored
      stray_rdata = 32'h1234_5678; force_ack = 1'b1;
      @(negedge clk); #1;
      force_ack = 1'b0;
      chk("stray_ready", 32'(o_mem_ready), 32'd0);
      chk("stray_rdata", o_mem_rdata, 32'h5A5A_0001);
      chk("stray_req", 32'(o_cpu_req), 32'd0);
      idle_gap();

      // reset two cycles into REQ, with a sticky flag set beforehand
      drive(32'h0C, 32'h0, 4'b0100);
      wait_ready(20, cyc, rd, req1);
      idle_gap();
      chk("pre_rst_err", 32'(o_err_partial), 32'd1);
      ack_en = 1'b0;
      drive(32'h84, 32'h0, 4'h0);
      repeat (2) @(negedge clk);
      #1;
      chk("pre_rst_req", 32'(o_cpu_req), 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_req",   32'(o_cpu_req), 32'd0);
      chk("mid_rst_ready", 32'(o_mem_ready), 32'd0);
      chk("mid_rst_err",   32'(o_err_partial), 32'd0);
      chk("mid_rst_addr",  o_cpu_addr, 32'd0);
      release_cpu();
      @(negedge clk); #1;
      reset = 1'b0;
      idle_gap();
      ack_en = 1'b1; ack_delay = 2; ack_data = 32'h0000_0077;
      drive(32'h80, 32'h0, 4'h0);
      wait_ready(50, cyc, rd, req1);
      release_cpu();
      chk("post_rst_cycles", 32'(cyc), 32'd3);
      chk("post_rst_data", rd, 32'h0000_0077);
      idle_gap();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
